// File: rtl/shift_rx_pkg.sv
// Shared types and constants for the shift_rx8 serial byte receiver.
// SHIFT_RX_PARITY_EN selects a 9-bit frame whose last bit is even parity.
package shift_rx_pkg;

   localparam int unsigned BYTE_W = 8;
   localparam int unsigned CNT_W  = 4;

`ifdef SHIFT_RX_PARITY_EN
   localparam int unsigned FRAME_BITS = 9;
`else
   localparam int unsigned FRAME_BITS = 8;
`endif

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      STROBE
   } rx_state_t;

   // Even parity holds when data bits plus parity bit contain an even number of ones.
   function automatic logic even_parity_ok(input logic [BYTE_W-1:0] data, input logic par);
      return ~(^{data, par});
   endfunction

endpackage

// File: rtl/shift_rx8_sync_edge.sv
// Multi-flop synchronizer with rise/fall pulses derived from the synchronized level.
module sync_edge #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic        RST_VAL     = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic sync_o,
   output logic rise_o,
   output logic fall_o
);

   logic [SYNC_STAGES-1:0] chain_q;
   logic [SYNC_STAGES-1:0] chain_d;
   logic                   prev_q;
   logic                   prev_d;

   // Shift the raw input down the chain and remember the previous synced level.
   always_comb begin
      chain_d = {chain_q[SYNC_STAGES-2:0], d_i};
      prev_d  = chain_q[SYNC_STAGES-1];
   end

   // Synchronizer and edge-history flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chain_q <= {SYNC_STAGES{RST_VAL}};
         prev_q  <= RST_VAL;
      end else begin
         chain_q <= chain_d;
         prev_q  <= prev_d;
      end
   end

   // Level and single-cycle edge pulses on the synchronized signal.
   always_comb begin
      sync_o = chain_q[SYNC_STAGES-1];
      rise_o = chain_q[SYNC_STAGES-1] & ~prev_q;
      fall_o = ~chain_q[SYNC_STAGES-1] & prev_q;
   end

endmodule

// File: rtl/shift_rx8.sv
// Serial-to-parallel byte receiver feeding an 8-bit enable latch.
// sck/cs_n/sdi are synchronized into clk; data_o only updates with a 1-clk latch_en_o.
// Optional macro SHIFT_RX_PARITY_EN adds a 9th even-parity bit and parity_err_o.
module shift_rx8
   import shift_rx_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned MSB_FIRST   = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sck,
   input  logic              cs_n,
   input  logic              sdi,
   output logic [BYTE_W-1:0] data_o,
   output logic              latch_en_o,
   output logic              busy_o,
   output logic              frame_err_o
`ifdef SHIFT_RX_PARITY_EN
   ,
   output logic              parity_err_o
`endif
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_BITS);
   localparam logic [CNT_W-1:0] DATA_CNT = CNT_W'(BYTE_W);

   logic sck_sync, sck_rise, sck_fall;
   logic cs_sync, cs_rise, cs_fall;
   logic sdi_sync, sdi_rise, sdi_fall;
   logic unused_edges;

   rx_state_t         state_q, state_d;
   logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [BYTE_W-1:0] shift_q, shift_d;
   logic [BYTE_W-1:0] data_q, data_d;
   logic              latch_en_q, latch_en_d;
   logic              frame_err_q, frame_err_d;
`ifdef SHIFT_RX_PARITY_EN
   logic              par_q, par_d;
   logic              parity_err_q, parity_err_d;
`endif

   sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
      .clk    (clk),
      .rst_n  (rst_n),
      .d_i    (sck),
      .sync_o (sck_sync),
      .rise_o (sck_rise),
      .fall_o (sck_fall)
   );

   // cs_n chain resets low so a select still held low at reset release
   // cannot look like a fresh frame start.
   sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_cs (
      .clk    (clk),
      .rst_n  (rst_n),
      .d_i    (cs_n),
      .sync_o (cs_sync),
      .rise_o (cs_rise),
      .fall_o (cs_fall)
   );

   sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sdi (
      .clk    (clk),
      .rst_n  (rst_n),
      .d_i    (sdi),
      .sync_o (sdi_sync),
      .rise_o (sdi_rise),
      .fall_o (sdi_fall)
   );

   assign unused_edges = sck_sync ^ sck_fall ^ sdi_rise ^ sdi_fall;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; a full frame takes priority over a late cs_n rise.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (cs_fall) state_d = SHIFT;
         end
         SHIFT: begin
            if (bit_cnt_q == LAST_CNT) state_d = STROBE;
            else if (cs_rise)          state_d = IDLE;
         end
         STROBE: begin
            state_d = cs_sync ? IDLE : SHIFT;
         end
         default: state_d = IDLE;
      endcase
   end

   // Datapath and registered-strobe next values; cs_n rise beats a coincident sck rise.
   always_comb begin
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      data_d      = data_q;
      latch_en_d  = 1'b0;
      frame_err_d = 1'b0;
`ifdef SHIFT_RX_PARITY_EN
      par_d        = par_q;
      parity_err_d = 1'b0;
`endif
      unique case (state_q)
         IDLE: begin
            bit_cnt_d = '0;
         end
         SHIFT: begin
            if (bit_cnt_q == LAST_CNT) begin
               bit_cnt_d = bit_cnt_q;
            end else if (cs_rise) begin
               bit_cnt_d   = '0;
               frame_err_d = (bit_cnt_q != '0);
            end else if (sck_rise) begin
               bit_cnt_d = bit_cnt_q + CNT_W'(1);
               if (bit_cnt_q < DATA_CNT) begin
                  if (MSB_FIRST != 0) shift_d = {shift_q[BYTE_W-2:0], sdi_sync};
                  else                shift_d = {sdi_sync, shift_q[BYTE_W-1:1]};
               end
`ifdef SHIFT_RX_PARITY_EN
               else begin
                  par_d = sdi_sync;
               end
`endif
            end
         end
         STROBE: begin
            bit_cnt_d = '0;
`ifdef SHIFT_RX_PARITY_EN
            if (even_parity_ok(shift_q, par_q)) begin
               data_d     = shift_q;
               latch_en_d = 1'b1;
            end else begin
               parity_err_d = 1'b1;
            end
`else
            data_d     = shift_q;
            latch_en_d = 1'b1;
`endif
         end
         default: bit_cnt_d = '0;
      endcase
   end

   // Datapath and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         data_q      <= '0;
         latch_en_q  <= 1'b0;
         frame_err_q <= 1'b0;
`ifdef SHIFT_RX_PARITY_EN
         par_q        <= 1'b0;
         parity_err_q <= 1'b0;
`endif
      end else begin
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         data_q      <= data_d;
         latch_en_q  <= latch_en_d;
         frame_err_q <= frame_err_d;
`ifdef SHIFT_RX_PARITY_EN
         par_q        <= par_d;
         parity_err_q <= parity_err_d;
`endif
      end
   end

   // Output drive.
   always_comb begin
      data_o      = data_q;
      latch_en_o  = latch_en_q;
      frame_err_o = frame_err_q;
      busy_o      = (state_q != IDLE);
`ifdef SHIFT_RX_PARITY_EN
      parity_err_o = parity_err_q;
`endif
   end

endmodule

// File: tb/tb_shift_rx8.sv
// Directed bench for shift_rx8: one MSB-first and one LSB-first instance share the serial inputs.
module tb_shift_rx8;

   localparam int unsigned SYNC = 3;

   logic       clk = 1'b0;
   logic       rst_n, sck, cs_n, sdi;
   logic [7:0] data_m, data_l;
   logic       le_m, le_l, busy_m, busy_l, fe_m, fe_l;
`ifdef SHIFT_RX_PARITY_EN
   logic       pe_m, pe_l;
`endif

   always #5 clk = ~clk;

   shift_rx8 #(.SYNC_STAGES(SYNC), .MSB_FIRST(1)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .sck         (sck),
      .cs_n        (cs_n),
      .sdi         (sdi),
      .data_o      (data_m),
      .latch_en_o  (le_m),
      .busy_o      (busy_m),
      .frame_err_o (fe_m)
`ifdef SHIFT_RX_PARITY_EN
      ,
      .parity_err_o(pe_m)
`endif
   );

   shift_rx8 #(.SYNC_STAGES(SYNC), .MSB_FIRST(0)) dut_lsb (
      .clk         (clk),
      .rst_n       (rst_n),
      .sck         (sck),
      .cs_n        (cs_n),
      .sdi         (sdi),
      .data_o      (data_l),
      .latch_en_o  (le_l),
      .busy_o      (busy_l),
      .frame_err_o (fe_l)
`ifdef SHIFT_RX_PARITY_EN
      ,
      .parity_err_o(pe_l)
`endif
   );

   int cyc = 0;
   always @(posedge clk) cyc++;

   int n_cmp = 0;
   int n_fail = 0;
   int le_cnt_m = 0, le_cnt_l = 0, fe_cnt_m = 0, fe_cnt_l = 0;
   int pe_cnt_m = 0, pe_cnt_l = 0, busy_drop = 0;
   int last_le_cyc_m = 0, last_le_cyc_l = 0;
   int rise_cyc = 0;
   bit in_frame = 1'b0;
   logic [7:0] cap_m[$];
   logic [7:0] cap_l[$];

   // Pulse counters and captured bytes, sampled mid-cycle.
   always @(negedge clk) begin
      if (le_m) begin le_cnt_m++; last_le_cyc_m = cyc; cap_m.push_back(data_m); end
      if (le_l) begin le_cnt_l++; last_le_cyc_l = cyc; cap_l.push_back(data_l); end
      if (fe_m) fe_cnt_m++;
      if (fe_l) fe_cnt_l++;
`ifdef SHIFT_RX_PARITY_EN
      if (pe_m) pe_cnt_m++;
      if (pe_l) pe_cnt_l++;
`endif
      if (in_frame && (!busy_m || !busy_l)) busy_drop++;
   end

   typedef struct {
      logic [7:0] wire_b;
      logic [7:0] exp_m;
      logic [7:0] exp_l;
   } vec_t;

   vec_t vecs[6];

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // sck period 8 clk: sdi set while sck low, rise after 4 clk, fall 4 clk later.
   task automatic send_bit(input logic b);
      sdi = b;
      tick(4);
      sck = 1'b1;
      rise_cyc = cyc;
      tick(4);
      sck = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) send_bit(b[i]);
   endtask

   task automatic frame_begin();
      cs_n = 1'b0;
      tick(6);
      in_frame = 1'b1;
   endtask

   task automatic frame_end();
      in_frame = 1'b0;
      tick(4);
      cs_n = 1'b1;
      tick(10);
   endtask

   int s_le_m, s_le_l, s_fe_m, s_fe_l, s_pe_m, s_pe_l, s_bd, s_q;

   task automatic snap();
      s_le_m = le_cnt_m; s_le_l = le_cnt_l;
      s_fe_m = fe_cnt_m; s_fe_l = fe_cnt_l;
      s_pe_m = pe_cnt_m; s_pe_l = pe_cnt_l;
      s_bd   = busy_drop; s_q = cap_m.size();
   endtask

   initial begin
      vecs[0] = '{8'hA5, 8'hA5, 8'hA5};
      vecs[1] = '{8'h01, 8'h01, 8'h80};
      vecs[2] = '{8'h80, 8'h80, 8'h01};
      vecs[3] = '{8'h12, 8'h12, 8'h48};
      vecs[4] = '{8'hC6, 8'hC6, 8'h63};
      vecs[5] = '{8'hFF, 8'hFF, 8'hFF};

      rst_n = 1'b0; cs_n = 1'b1; sck = 1'b0; sdi = 1'b0;
      for (int i = 0; i < 4; i++) begin
         sck = 1'b1; tick(2); sck = 1'b0; tick(2);
      end
      chk("reset_data_m", data_m, 8'h00);
      chk("reset_data_l", data_l, 8'h00);
      chk("reset_latch_en", le_m, 1'b0);
      chk("reset_busy", busy_m, 1'b0);
      chk("reset_latch_cnt", le_cnt_m, 0);
      rst_n = 1'b1;
      tick(6);

      // Single-byte frames with latency check.
      for (int v = 0; v < 6; v++) begin
         snap();
         frame_begin();
         send_byte(vecs[v].wire_b);
`ifdef SHIFT_RX_PARITY_EN
         send_bit(^vecs[v].wire_b);
`endif
         frame_end();
         chk($sformatf("vec%0d_data_m", v), data_m, vecs[v].exp_m);
         chk($sformatf("vec%0d_data_l", v), data_l, vecs[v].exp_l);
         chk($sformatf("vec%0d_latch_pulses_m", v), le_cnt_m - s_le_m, 1);
         chk($sformatf("vec%0d_latch_pulses_l", v), le_cnt_l - s_le_l, 1);
         chk($sformatf("vec%0d_latency", v), last_le_cyc_m - rise_cyc, SYNC + 3);
         chk($sformatf("vec%0d_frame_err", v), fe_cnt_m - s_fe_m, 0);
         chk($sformatf("vec%0d_busy_after", v), busy_m, 1'b0);
      end

      // Two bytes in one frame.
      snap();
      frame_begin();
      send_byte(8'h3C);
`ifdef SHIFT_RX_PARITY_EN
      send_bit(1'b0);
`endif
      send_byte(8'hC3);
`ifdef SHIFT_RX_PARITY_EN
      send_bit(1'b0);
`endif
      frame_end();
      chk("b2b_pulses_m", cap_m.size() - s_q, 2);
      chk("b2b_pulses_l", le_cnt_l - s_le_l, 2);
      if (cap_m.size() - s_q == 2 && cap_l.size() - s_q == 2) begin
         chk("b2b_first_m", cap_m[s_q], 8'h3C);
         chk("b2b_second_m", cap_m[s_q+1], 8'hC3);
         chk("b2b_first_l", cap_l[s_q], 8'h3C);
         chk("b2b_second_l", cap_l[s_q+1], 8'hC3);
      end
      chk("b2b_busy_drops", busy_drop - s_bd, 0);

      // cs_n rises after 5 bits.
      snap();
      frame_begin();
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
      in_frame = 1'b0;
      cs_n = 1'b1;
      tick(10);
      chk("ferr5_pulses_m", fe_cnt_m - s_fe_m, 1);
      chk("ferr5_pulses_l", fe_cnt_l - s_fe_l, 1);
      chk("ferr5_no_latch", le_cnt_m - s_le_m, 0);
      chk("ferr5_data_hold", data_m, 8'hC3);
      chk("ferr5_busy", busy_m, 1'b0);

      // Last bit's sck rise coincides with cs_n rise: the bit is dropped.
      snap();
      frame_begin();
      for (int i = 0; i < 7; i++) send_bit(1'b1);
      in_frame = 1'b0;
      sdi = 1'b1;
      tick(4);
      sck = 1'b1; cs_n = 1'b1;
      tick(4);
      sck = 1'b0;
      tick(10);
      chk("tie7_frame_err", fe_cnt_m - s_fe_m, 1);
      chk("tie7_no_latch", le_cnt_m - s_le_m, 0);
      chk("tie7_data_hold", data_m, 8'hC3);

      // Coincident edges with no bits pending: clean close.
      snap();
      frame_begin();
      send_byte(8'h5A);
`ifdef SHIFT_RX_PARITY_EN
      send_bit(1'b0);
`endif
      in_frame = 1'b0;
      sdi = 1'b0;
      tick(4);
      sck = 1'b1; cs_n = 1'b1;
      tick(4);
      sck = 1'b0;
      tick(10);
      chk("tie0_latch", le_cnt_m - s_le_m, 1);
      chk("tie0_data", data_m, 8'h5A);
      chk("tie0_no_frame_err", fe_cnt_m - s_fe_m, 0);
      chk("tie0_busy", busy_m, 1'b0);

      // Reset mid-byte, then bits without a fresh cs_n fall, then a proper frame.
      frame_begin();
      send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
      in_frame = 1'b0;
      rst_n = 1'b0;
      sck = 1'b1; tick(1); sck = 1'b0; tick(2);
      chk("rstmid_data_m", data_m, 8'h00);
      chk("rstmid_data_l", data_l, 8'h00);
      chk("rstmid_busy", busy_m, 1'b0);
      rst_n = 1'b1;
      tick(2);
      snap();
      send_byte(8'hFF);
`ifdef SHIFT_RX_PARITY_EN
      send_bit(1'b0);
`endif
      tick(8);
      chk("idle_sck_no_latch", le_cnt_m - s_le_m, 0);
      chk("idle_sck_busy", busy_m, 1'b0);
      cs_n = 1'b1;
      tick(8);
      frame_begin();
      send_byte(8'h80);
`ifdef SHIFT_RX_PARITY_EN
      send_bit(1'b1);
`endif
      frame_end();
      chk("after_rst_data_m", data_m, 8'h80);
      chk("after_rst_data_l", data_l, 8'h01);
      chk("after_rst_latch", le_cnt_m - s_le_m, 1);

`ifdef SHIFT_RX_PARITY_EN
      snap();
      frame_begin(); send_byte(8'h07); send_bit(1'b1); frame_end();
      chk("par_good_latch", le_cnt_m - s_le_m, 1);
      chk("par_good_data_m", data_m, 8'h07);
      chk("par_good_data_l", data_l, 8'hE0);
      frame_begin(); send_byte(8'h55); send_bit(1'b0); frame_end();
      chk("par_good2_data_m", data_m, 8'h55);
      snap();
      frame_begin(); send_byte(8'h07); send_bit(1'b0); frame_end();
      chk("par_bad_err_m", pe_cnt_m - s_pe_m, 1);
      chk("par_bad_err_l", pe_cnt_l - s_pe_l, 1);
      chk("par_bad_no_latch", le_cnt_m - s_le_m, 0);
      chk("par_bad_data_m", data_m, 8'h55);
      chk("par_bad_data_l", data_l, 8'hAA);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
